// File: rtl/bwt_req_queue.sv
// BWT backward-pipeline request queue: buffers k/l occurrence lookups and
// issues them to memory one cache line at a time. When k and l fall on the
// same line, a single shared request is issued instead of two.
module bwt_req_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     request_valid,
    input  logic [41:0]              addr_k,
    input  logic [41:0]              addr_l,
    input  logic [8:0]               read_num,
    output logic                     stall,
    output logic                     mem_req_valid,
    output logic [41:0]              mem_req_addr,
    output logic [10:0]              mem_req_tag,
    input  logic                     mem_req_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned ADDRW = 42;
    localparam int unsigned RNW   = 9;

    typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L, ISSUE_KL} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_stall;
    logic               r_overflow;
    logic               r_mem_req_valid;
    logic [ADDRW-1:0]   r_mem_req_addr;
    logic [10:0]        r_mem_req_tag;

    logic [ADDRW-1:0]   r_mem_k  [DEPTH];
    logic [ADDRW-1:0]   r_mem_l  [DEPTH];
    logic [RNW-1:0]     r_mem_rn [DEPTH];

    logic               w_pop;
    logic               w_push;
    logic [CW-1:0]      w_count_pp;
    logic [CW-1:0]      w_count_next;
    logic [AW-1:0]      w_head_ptr;
    logic [ADDRW-1:0]   w_head_k;
    logic [ADDRW-1:0]   w_head_l;
    logic [RNW-1:0]     w_head_rn;
    logic               w_head_shared;
    logic               w_valid_next;
    logic [ADDRW-1:0]   w_addr_next;
    logic [10:0]        w_tag_next;

    // Push/pop qualification and the head entry as it will be after this edge
    always_comb begin
        w_pop        = r_mem_req_valid & mem_req_ready &
                       ((r_state == ISSUE_L) || (r_state == ISSUE_KL));
        w_push       = request_valid & ((r_count < CW'(DEPTH)) | w_pop);
        w_count_pp   = r_count - CW'(w_pop);
        w_count_next = w_count_pp + CW'(w_push);
        w_head_ptr   = r_rd_ptr + AW'(w_pop);
        // An empty post-pop queue means the incoming entry becomes the head
        if (w_count_pp == '0) begin
            w_head_k  = addr_k;
            w_head_l  = addr_l;
            w_head_rn = read_num;
        end else begin
            w_head_k  = r_mem_k[w_head_ptr];
            w_head_l  = r_mem_l[w_head_ptr];
            w_head_rn = r_mem_rn[w_head_ptr];
        end
        w_head_shared = (w_head_k == w_head_l);
    end

    // Issue FSM next-state and next registered request outputs
    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_addr_next  = '0;
        w_tag_next   = '0;
        case (r_state)
            IDLE: begin
                if (w_count_next != '0)
                    w_state_next = w_head_shared ? ISSUE_KL : ISSUE_K;
            end
            ISSUE_K: begin
                if (mem_req_ready)
                    w_state_next = ISSUE_L;
            end
            ISSUE_L, ISSUE_KL: begin
                if (mem_req_ready) begin
                    if (w_count_next != '0)
                        w_state_next = w_head_shared ? ISSUE_KL : ISSUE_K;
                    else
                        w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        case (w_state_next)
            ISSUE_K: begin
                w_valid_next = 1'b1;
                w_addr_next  = w_head_k;
                w_tag_next   = {w_head_rn, 2'b01};
            end
            ISSUE_L: begin
                w_valid_next = 1'b1;
                w_addr_next  = w_head_l;
                w_tag_next   = {w_head_rn, 2'b10};
            end
            ISSUE_KL: begin
                w_valid_next = 1'b1;
                w_addr_next  = w_head_k;
                w_tag_next   = {w_head_rn, 2'b11};
            end
            default: begin
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State, pointers, occupancy and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_stall         <= 1'b0;
            r_overflow      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_tag   <= '0;
        end else begin
            r_state         <= w_state_next;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count         <= w_count_next;
            r_stall         <= (w_count_next >= CW'(DEPTH - MARGIN));
            r_overflow      <= r_overflow | (request_valid & ~w_push);
            r_mem_req_valid <= w_valid_next;
            r_mem_req_addr  <= w_addr_next;
            r_mem_req_tag   <= w_tag_next;
        end
    end

    // Entry storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_k[r_wr_ptr]  <= addr_k;
            r_mem_l[r_wr_ptr]  <= addr_l;
            r_mem_rn[r_wr_ptr] <= read_num;
        end
    end

    assign stall         = r_stall;
    assign overflow      = r_overflow;
    assign count         = r_count;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_tag   = r_mem_req_tag;

endmodule

// File: tb/tb_bwt_req_queue.sv
// Directed bench for bwt_req_queue: vector table plus hand-written
// back-pressure, overflow/drain, full push+pop and mid-transfer reset sequences.
module tb_bwt_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        request_valid;
    logic [41:0] addr_k;
    logic [41:0] addr_l;
    logic [8:0]  read_num;
    logic        stall;
    logic        mem_req_valid;
    logic [41:0] mem_req_addr;
    logic [10:0] mem_req_tag;
    logic        mem_req_ready;
    logic        overflow;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    bwt_req_queue #(.DEPTH(16), .MARGIN(4)) dut (
        .clk(clk), .rst(rst), .request_valid(request_valid),
        .addr_k(addr_k), .addr_l(addr_l), .read_num(read_num),
        .stall(stall), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [41:0] k;
        logic [41:0] l;
        logic [8:0]  rn;
        logic        rdy;
        logic        ev;
        logic [41:0] ea;
        logic [10:0] et;
        logic [4:0]  ec;
        logic        es;
    } vec_t;

    vec_t vt[12];

    function automatic logic [10:0] tg(input logic [8:0] rn, input logic [1:0] s);
        return {rn, s};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it for sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [41:0] k, input logic [41:0] l,
                         input logic [8:0] rn, input logic rdy);
        request_valid = rv;
        addr_k        = k;
        addr_l        = l;
        read_num      = rn;
        mem_req_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 42'h0, 42'h0, 9'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        vt[0]  = '{1'b1, 42'h100, 42'h200, 9'd5, 1'b1, 1'b1, 42'h100, tg(9'd5, 2'b01), 5'd1, 1'b0};
        vt[1]  = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b1, 42'h200, tg(9'd5, 2'b10), 5'd1, 1'b0};
        vt[2]  = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b0, 42'h0,   11'h0,           5'd0, 1'b0};
        vt[3]  = '{1'b1, 42'h3AB, 42'h3AB, 9'd7, 1'b1, 1'b1, 42'h3AB, tg(9'd7, 2'b11), 5'd1, 1'b0};
        vt[4]  = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b0, 42'h0,   11'h0,           5'd0, 1'b0};
        vt[5]  = '{1'b1, 42'h10,  42'h20,  9'd1, 1'b1, 1'b1, 42'h10,  tg(9'd1, 2'b01), 5'd1, 1'b0};
        vt[6]  = '{1'b1, 42'h30,  42'h30,  9'd2, 1'b1, 1'b1, 42'h20,  tg(9'd1, 2'b10), 5'd2, 1'b0};
        vt[7]  = '{1'b1, 42'h40,  42'h50,  9'd3, 1'b1, 1'b1, 42'h30,  tg(9'd2, 2'b11), 5'd2, 1'b0};
        vt[8]  = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b0, 1'b1, 42'h30,  tg(9'd2, 2'b11), 5'd2, 1'b0};
        vt[9]  = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b1, 42'h40,  tg(9'd3, 2'b01), 5'd1, 1'b0};
        vt[10] = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b1, 42'h50,  tg(9'd3, 2'b10), 5'd1, 1'b0};
        vt[11] = '{1'b0, 42'h0,   42'h0,   9'd0, 1'b1, 1'b0, 42'h0,   11'h0,           5'd0, 1'b0};

        do_reset();
        chk("rst.valid",    64'(mem_req_valid), 64'd0);
        chk("rst.addr",     64'(mem_req_addr),  64'd0);
        chk("rst.tag",      64'(mem_req_tag),   64'd0);
        chk("rst.count",    64'(count),         64'd0);
        chk("rst.stall",    64'(stall),         64'd0);
        chk("rst.overflow", 64'(overflow),      64'd0);

        // Single, shared-line and back-to-back requests from the table
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].rv, vt[i].k, vt[i].l, vt[i].rn, vt[i].rdy);
            tick();
            chk($sformatf("v%0d.valid", i), 64'(mem_req_valid), 64'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("v%0d.addr", i), 64'(mem_req_addr), 64'(vt[i].ea));
                chk($sformatf("v%0d.tag", i),  64'(mem_req_tag),  64'(vt[i].et));
            end
            chk($sformatf("v%0d.count", i), 64'(count), 64'(vt[i].ec));
            chk($sformatf("v%0d.stall", i), 64'(stall), 64'(vt[i].es));
        end

        // Back-pressure then overflow: 17 pushes with ready low
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 42'(32'h1000 + i), 42'(32'h2000 + i), 9'(i), 1'b0);
            tick();
            chk($sformatf("bp%0d.valid", i), 64'(mem_req_valid), 64'd1);
            chk($sformatf("bp%0d.addr", i),  64'(mem_req_addr),  64'h1000);
            chk($sformatf("bp%0d.tag", i),   64'(mem_req_tag),   64'(tg(9'd0, 2'b01)));
            chk($sformatf("bp%0d.stall", i), 64'(stall),         64'((i + 1) >= 12));
            chk($sformatf("bp%0d.count", i), 64'(count),         64'(((i + 1) > 16) ? 16 : (i + 1)));
            chk($sformatf("bp%0d.ovf", i),   64'(overflow),      64'(i == 16));
        end

        // Drain: exactly 16 entries, k then l each, in push order
        drive(1'b0, 42'h0, 42'h0, 9'd0, 1'b1);
        n = 0;
        for (int c = 0; c < 100 && n < 32; c++) begin
            if (mem_req_valid) begin
                chk($sformatf("dr%0d.addr", n), 64'(mem_req_addr),
                    64'(((n % 2) == 0) ? (32'h1000 + n / 2) : (32'h2000 + n / 2)));
                chk($sformatf("dr%0d.tag", n), 64'(mem_req_tag),
                    64'(tg(9'(n / 2), ((n % 2) == 0) ? 2'b01 : 2'b10)));
                n++;
            end
            tick();
        end
        chk("drain.n",        64'(n),             64'd32);
        chk("drain.valid",    64'(mem_req_valid), 64'd0);
        chk("drain.count",    64'(count),         64'd0);
        chk("drain.overflow", 64'(overflow),      64'd1);
        chk("drain.stall",    64'(stall),         64'd0);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 42'(32'h500 + i), 42'(32'h500 + i), 9'(i), 1'b0);
            tick();
        end
        chk("full.count", 64'(count), 64'd16);
        chk("full.tag",   64'(mem_req_tag), 64'(tg(9'd0, 2'b11)));
        drive(1'b1, 42'h600, 42'h601, 9'd20, 1'b1);
        tick();
        chk("pp.count",    64'(count),        64'd16);
        chk("pp.overflow", 64'(overflow),     64'd0);
        chk("pp.addr",     64'(mem_req_addr), 64'h501);
        chk("pp.tag",      64'(mem_req_tag),  64'(tg(9'd1, 2'b11)));

        // Reset mid-transfer in ISSUE_L with 3 queued, colliding with a push
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 42'(32'h700 + i), 42'(32'h800 + i), 9'(i), 1'b0);
            tick();
        end
        drive(1'b0, 42'h0, 42'h0, 9'd0, 1'b1);
        tick();
        chk("mr.pre_addr", 64'(mem_req_addr), 64'h800);
        chk("mr.pre_tag",  64'(mem_req_tag),  64'(tg(9'd0, 2'b10)));
        rst = 1'b1;
        drive(1'b1, 42'h900, 42'h901, 9'd9, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 42'h0, 42'h0, 9'd0, 1'b1);
        chk("mr.valid", 64'(mem_req_valid), 64'd0);
        chk("mr.count", 64'(count),         64'd0);
        chk("mr.stall", 64'(stall),         64'd0);
        chk("mr.addr",  64'(mem_req_addr),  64'd0);
        chk("mr.tag",   64'(mem_req_tag),   64'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("mr_after%0d.valid", c), 64'(mem_req_valid), 64'd0);
        end
        chk("mr_after.count", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bwt_req_queue.md
BWT_REQ_QUEUE -- requirements
Module: bwt_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count of the request FIFO (power of two).
REQ-002 SHALL have parameter MARGIN, default 4: free entries reserved for requests already in the backward pipeline.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port request_valid  input  1  the backward control stage issues one k/l lookup this cycle.
REQ-006 SHALL have port addr_k  input  42  cache-line address for the k occurrence lookup.
REQ-007 SHALL have port addr_l  input  42  cache-line address for the l occurrence lookup.
REQ-008 SHALL have port read_num  input  9  read slot that owns the request.
REQ-009 SHALL have port stall  output  1  registered back-pressure to the backward pipeline.
REQ-010 SHALL have port mem_req_valid  output  1  a memory read request is presented.
REQ-011 SHALL have port mem_req_addr  output  42  cache-line address of the presented request.
REQ-012 SHALL have port mem_req_tag  output  11  {read_num[8:0], sel[1:0]}; sel 01 = k, 10 = l, 11 = k and l share the line.
REQ-013 SHALL have port mem_req_ready  input  1  memory side accepts the request this cycle.
REQ-014 SHALL have port overflow  output  1  sticky error: a request was dropped.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL push {read_num, addr_k, addr_l} at the rising edge when request_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-017 SHALL drop the request and set overflow=1 when request_valid=1, count==DEPTH and no pop occurs in that cycle; overflow stays 1 until rst.
REQ-018 SHALL make a pushed entry visible at the head no earlier than the cycle after the push edge (push at edge N means mem_req_valid can first be 1 in cycle N+1).
REQ-019 SHALL run an issue FSM with states IDLE, ISSUE_K, ISSUE_L, ISSUE_KL.
REQ-020 IDLE: mem_req_valid=0; if count>0, go to ISSUE_KL when head addr_k==addr_l, otherwise to ISSUE_K.
REQ-021 ISSUE_K: present head addr_k with sel=01; on mem_req_ready go to ISSUE_L.
REQ-022 ISSUE_L: present head addr_l with sel=10; on mem_req_ready pop the head, then go to ISSUE_K/ISSUE_KL if the next entry exists, else IDLE.
REQ-023 ISSUE_KL: present addr_k with sel=11 (one request only); on mem_req_ready pop, with the same next-state rule as ISSUE_L.
REQ-024 SHALL hold mem_req_valid, addr and tag stable while mem_req_valid=1 and mem_req_ready=0.
REQ-025 SHALL take the next-state decision after a pop from the post-pop head, so back-to-back entries issue with no idle cycle.
REQ-026 SHALL keep count unchanged when a push and a pop occur in the same cycle; pointers wrap modulo DEPTH.
REQ-027 SHALL drive stall as a register: stall <= (count_next >= DEPTH-MARGIN), where count_next is the occupancy after the current edge.
REQ-028 SHALL ignore mem_req_ready when mem_req_valid=0.

Reset
REQ-029 When rst=1 at an edge, SHALL set: FSM=IDLE, pointers=0, count=0, mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, stall=0, overflow=0.
REQ-030 When rst is asserted mid-transfer, SHALL discard all queued and partially issued entries with no further request presented; rst takes priority over a simultaneous push.

Verification
REQ-031 Single request: read_num=5, addr_k=0x100, addr_l=0x200, ready held at 1 -> cycle N+1 addr 0x100 tag {5,01}; cycle N+2 addr 0x200 tag {5,10}; then count=0 and valid=0.
REQ-032 Shared line: addr_k=addr_l=0x3AB, read_num=7 -> exactly one request, addr 0x3AB, tag {7,11}.
REQ-033 Back-pressure: ready=0 with 12 pushes -> stall=1 on the edge after the 12th push; valid, addr and tag stay frozen on the first k request.
REQ-034 Overflow: ready=0 with 17 pushes (DEPTH=16) -> 17th dropped, overflow=1, count=16; after ready=1, exactly 16 entries drain in order.
REQ-035 Push and pop in the same cycle at count=16 -> push accepted, count remains 16, overflow remains 0.
REQ-036 rst pulsed while in ISSUE_L with 3 entries queued -> next cycle valid=0, count=0, stall=0, and no stale request appears afterwards.
